// File: rtl/iir_coeff_ctrl_pkg.sv
// Shared types, state encoding and built-in notch preset table for the
// biquad coefficient configuration controller.
package iir_pkg;

    typedef logic signed [19:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GAP,
        ST_VERIFY
    } state_t;

    localparam int NUM_PRESETS = 3;
    localparam int PRESET_WORDS = 5;

    // Rows: 1 MHz, 2 MHz, 2.4 MHz notch; columns: B0, B1, B2, A1, A2 (Q2.18)
    localparam coeff_t IIR_PRESETS [NUM_PRESETS][PRESET_WORDS] = '{
        '{20'h37061, 20'hC8F9F, 20'h37061, 20'hC8F9F, 20'h2E0C3},
        '{20'h37061, 20'h37061, 20'h37061, 20'h37061, 20'h2E0C3},
        '{20'h37061, 20'h5907C, 20'h37061, 20'h5907C, 20'h2E0C3}
    };

    // Safe lookup into the preset table; out-of-range selects return zero
    function automatic coeff_t preset_word(input logic [1:0] sel, input logic [2:0] idx);
        coeff_t w;
        w = '0;
        if (idx <= 3'd4) begin
            case (sel)
                2'd0: w = IIR_PRESETS[0][idx];
                2'd1: w = IIR_PRESETS[1][idx];
                2'd2: w = IIR_PRESETS[2][idx];
                default: w = '0;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/iir_coeff_ctrl.sv
// Coefficient configuration controller: gathers a five-word coefficient set
// into a shadow bank, commits it to the IIR filter in a sample gap (or after
// a timeout), then verifies the filter's readback against the shadow bank.
module iir_coeff_ctrl
    import iir_pkg::*;
#(
    parameter int COEFF_WIDTH    = 20,
    parameter int COEFF_DEPTH    = 5,
    parameter int DEFAULT_PRESET = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_wr_valid,
    output logic                                    cfg_wr_ready,
    input  logic [2:0]                              cfg_wr_addr,
    input  logic [COEFF_WIDTH-1:0]                  cfg_wr_data,
    input  logic                                    cfg_preset_load,
    input  logic [1:0]                              cfg_preset_sel,
    input  logic                                    cfg_commit,
    input  logic                                    sample_valid,
    output logic                                    coeff_wr_en,
    output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in,
    input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_rd,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    cfg_err,
    output logic                                    verify_err,
    output logic                                    forced
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                                  state;
    state_t                                  state_next;
    logic [CNT_W-1:0]                        wait_cnt;
    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow;
    logic [COEFF_DEPTH-1:0]                  wmask;

    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] upd_shadow;
    logic [COEFF_DEPTH-1:0]                  upd_mask;
    logic                                    upd_err;
    logic                                    take_update;
    logic                                    accept;
    logic                                    err_next;
    logic                                    force_now;
    logic                                    mismatch;
    logic                                    write_legal;
    logic                                    preset_legal;

    assign coeff_in     = shadow;
    assign busy         = (state != ST_IDLE);
    assign write_legal  = (int'(cfg_wr_addr) < COEFF_DEPTH);
    assign preset_legal = (cfg_preset_sel != 2'd3);

    // Candidate shadow/mask after this cycle's preset or write (preset wins)
    always_comb begin
        upd_shadow = shadow;
        upd_mask   = wmask;
        upd_err    = 1'b0;
        if (cfg_preset_load) begin
            if (preset_legal) begin
                for (int i = 0; i < COEFF_DEPTH; i++) begin
                    upd_shadow[i] = COEFF_WIDTH'(preset_word(cfg_preset_sel, 3'(i)));
                end
                upd_mask = '1;
            end else begin
                upd_err = 1'b1;
            end
        end else if (cfg_wr_valid) begin
            if (write_legal) begin
                for (int i = 0; i < COEFF_DEPTH; i++) begin
                    if (cfg_wr_addr == 3'(i)) begin
                        upd_shadow[i] = cfg_wr_data;
                        upd_mask[i]   = 1'b1;
                    end
                end
            end else begin
                upd_err = 1'b1;
            end
        end
    end

    // Next-state and per-cycle control outputs of the commit sequence
    always_comb begin
        state_next   = state;
        cfg_wr_ready = 1'b0;
        coeff_wr_en  = 1'b0;
        done         = 1'b0;
        take_update  = 1'b0;
        accept       = 1'b0;
        err_next     = 1'b0;
        force_now    = 1'b0;
        mismatch     = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_wr_ready = 1'b1;
                take_update  = 1'b1;
                err_next     = upd_err;
                if (cfg_commit) begin
                    if (&upd_mask) begin
                        accept     = 1'b1;
                        state_next = ST_WAIT_GAP;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_WAIT_GAP: begin
                if (!sample_valid) begin
                    coeff_wr_en = 1'b1;
                    state_next  = ST_VERIFY;
                end else if (wait_cnt == CNT_LAST) begin
                    coeff_wr_en = 1'b1;
                    force_now   = 1'b1;
                    state_next  = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                mismatch   = (coeff_rd != shadow);
                done       = !mismatch;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and gap-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT_GAP) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Shadow bank and written-word mask; mask empties after every verify
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COEFF_DEPTH; i++) begin
                shadow[i] <= COEFF_WIDTH'(preset_word(2'(DEFAULT_PRESET), 3'(i)));
            end
            wmask <= '0;
        end else if (take_update) begin
            shadow <= upd_shadow;
            wmask  <= upd_mask;
        end else if (state == ST_VERIFY) begin
            wmask <= '0;
        end
    end

    // Registered error pulse and the sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err    <= 1'b0;
            verify_err <= 1'b0;
            forced     <= 1'b0;
        end else begin
            cfg_err <= err_next;
            if (accept) begin
                verify_err <= 1'b0;
                forced     <= 1'b0;
            end else begin
                if (force_now) forced <= 1'b1;
                if (mismatch) verify_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Self-checking bench for iir_coeff_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the controller and a stand-in filter.
module tb_iir_coeff_ctrl;

    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_wr_valid = 1'b0;
    logic             cfg_wr_ready;
    logic [2:0]       cfg_wr_addr = '0;
    logic [19:0]      cfg_wr_data = '0;
    logic             cfg_preset_load = 1'b0;
    logic [1:0]       cfg_preset_sel = '0;
    logic             cfg_commit = 1'b0;
    logic             sample_valid = 1'b0;
    logic             coeff_wr_en;
    logic [4:0][19:0] coeff_in;
    logic [4:0][19:0] coeff_rd;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic             verify_err;
    logic             forced;

    logic             corrupt = 1'b0;
    logic [4:0][19:0] filt = '0;

    int n_pass = 0;
    int n_total = 0;

    logic [19:0] presets [3][5] = '{
        '{20'h37061, 20'hC8F9F, 20'h37061, 20'hC8F9F, 20'h2E0C3},
        '{20'h37061, 20'h37061, 20'h37061, 20'h37061, 20'h2E0C3},
        '{20'h37061, 20'h5907C, 20'h37061, 20'h5907C, 20'h2E0C3}
    };

    // Model state: shadow words, written mask, cycles since accepted commit,
    // the age at which the filter write happened, and the flag registers
    logic [19:0] m_shadow [5];
    logic [19:0] m_filt [5];
    bit   [4:0]  m_mask;
    int          m_age;
    int          m_wr_age;
    bit          m_err;
    bit          m_verr;
    bit          m_forced;

    iir_coeff_ctrl #(
        .COEFF_WIDTH(20),
        .COEFF_DEPTH(5),
        .DEFAULT_PRESET(2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cfg_preset_load(cfg_preset_load),
        .cfg_preset_sel(cfg_preset_sel),
        .cfg_commit(cfg_commit),
        .sample_valid(sample_valid),
        .coeff_wr_en(coeff_wr_en),
        .coeff_in(coeff_in),
        .coeff_rd(coeff_rd),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
        .verify_err(verify_err),
        .forced(forced)
    );

    always #5 clk = ~clk;

    // Stand-in filter: latches the parallel port on coeff_wr_en
    always @(posedge clk) begin
        if (coeff_wr_en) filt <= coeff_in;
    end

    always_comb begin
        coeff_rd = filt;
        if (corrupt) coeff_rd[4] = '0;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_shadow[i] = presets[2][i];
        m_mask   = '0;
        m_age    = 0;
        m_wr_age = 0;
        m_err    = 1'b0;
        m_verr   = 1'b0;
        m_forced = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_filt[i] = '0;
        model_reset();
    end

    // Every cycle: derive expected outputs from the model, compare, advance
    always @(negedge clk) begin : cmp_proc
        logic [19:0] rb [5];
        bit exp_busy;
        bit exp_wr;
        bit exp_done;
        bit match;
        bit err;
        if (!rst_n) model_reset();
        exp_busy = (m_age > 0);
        exp_wr   = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < 5; i++) rb[i] = m_filt[i];
        if (corrupt) rb[4] = '0;
        match = 1'b1;
        for (int i = 0; i < 5; i++) if (rb[i] != m_shadow[i]) match = 1'b0;
        if (exp_busy && m_wr_age == 0) exp_wr = !sample_valid || (m_age == TIMEOUT);
        if (exp_busy && m_wr_age > 0) exp_done = match;

        checkOutput("model.busy", 128'(busy), 128'(exp_busy));
        checkOutput("model.ready", 128'(cfg_wr_ready), 128'(!exp_busy));
        checkOutput("model.wr_en", 128'(coeff_wr_en), 128'(exp_wr));
        checkOutput("model.done", 128'(done), 128'(exp_done));
        checkOutput("model.cfg_err", 128'(cfg_err), 128'(m_err));
        checkOutput("model.verify_err", 128'(verify_err), 128'(m_verr));
        checkOutput("model.forced", 128'(forced), 128'(m_forced));
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("model.coeff_in[%0d]", i), 128'(coeff_in[i]), 128'(m_shadow[i]));
        end

        if (rst_n) begin
            if (!exp_busy) begin
                err = 1'b0;
                if (cfg_preset_load) begin
                    if (cfg_preset_sel != 2'd3) begin
                        for (int i = 0; i < 5; i++) m_shadow[i] = presets[cfg_preset_sel][i];
                        m_mask = 5'b11111;
                    end else begin
                        err = 1'b1;
                    end
                end else if (cfg_wr_valid) begin
                    if (cfg_wr_addr < 3'd5) begin
                        m_shadow[cfg_wr_addr] = cfg_wr_data;
                        m_mask[cfg_wr_addr] = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                if (cfg_commit) begin
                    if (m_mask == 5'b11111) begin
                        m_age    = 1;
                        m_wr_age = 0;
                        m_verr   = 1'b0;
                        m_forced = 1'b0;
                    end else begin
                        err = 1'b1;
                    end
                end
                m_err = err;
            end else if (m_wr_age == 0) begin
                m_err = 1'b0;
                if (exp_wr) begin
                    for (int i = 0; i < 5; i++) m_filt[i] = m_shadow[i];
                    m_wr_age = m_age;
                    if (sample_valid) m_forced = 1'b1;
                end
                m_age++;
            end else begin
                m_err = 1'b0;
                if (!match) m_verr = 1'b1;
                m_mask   = '0;
                m_age    = 0;
                m_wr_age = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int cycles, input int sv_pct);
        for (int c = 0; c < cycles; c++) begin
            cfg_wr_valid    = ($urandom_range(99) < 40);
            cfg_wr_addr     = 3'($urandom_range(7));
            cfg_wr_data     = 20'($urandom());
            cfg_preset_load = ($urandom_range(99) < 8);
            cfg_preset_sel  = 2'($urandom_range(3));
            cfg_commit      = ($urandom_range(99) < 15);
            sample_valid    = ($urandom_range(99) < sv_pct);
            corrupt         = ($urandom_range(99) < 5);
            step();
        end
    endtask

    // Commit already sampled; waits for coeff_wr_en while sample_valid is
    // held high for hold_cycles cycles, returns the cycle index or 0
    task automatic waitWrite(input int hold_cycles, output int found);
        found = 0;
        for (int k = 1; k <= 100; k++) begin
            sample_valid = (k <= hold_cycles);
            @(negedge clk);
            if (coeff_wr_en) begin
                found = k;
                break;
            end
            step();
        end
    endtask

    initial begin
        int k;
        // Reset state pinned to literal preset 2
        step();
        step();
        @(negedge clk);
        checkOutput("reset.b1", 128'(coeff_in[1]), 128'h5907C);
        checkOutput("reset.a2", 128'(coeff_in[4]), 128'h2E0C3);
        checkOutput("reset.ready", 128'(cfg_wr_ready), 128'h1);
        checkOutput("reset.flags", 128'({busy, done, cfg_err, verify_err, forced, coeff_wr_en}), 128'h0);
        step();
        rst_n = 1'b1;
        step();

        // Full register write then gap commit: wr_en at N+1, done at N+2
        for (int i = 0; i < 5; i++) begin
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 3'(i);
            cfg_wr_data  = 20'h10000 + 20'(i);
            step();
        end
        cfg_wr_valid = 1'b0;
        cfg_commit   = 1'b1;
        sample_valid = 1'b0;
        step();
        cfg_commit = 1'b0;
        @(negedge clk);
        checkOutput("min.wr_en", 128'(coeff_wr_en), 128'h1);
        checkOutput("min.coeff_in4", 128'(coeff_in[4]), 128'h10004);
        step();
        @(negedge clk);
        checkOutput("min.done", 128'(done), 128'h1);
        checkOutput("min.readback4", 128'(coeff_rd[4]), 128'h10004);
        step();
        @(negedge clk);
        checkOutput("min.idle", 128'(busy), 128'h0);

        // Incomplete mask: commit rejected
        for (int i = 0; i < 4; i++) begin
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 3'(i);
            cfg_wr_data  = 20'h20000 + 20'(i);
            step();
        end
        cfg_wr_valid = 1'b0;
        cfg_commit   = 1'b1;
        step();
        cfg_commit = 1'b0;
        @(negedge clk);
        checkOutput("reject.cfg_err", 128'(cfg_err), 128'h1);
        checkOutput("reject.busy", 128'(busy), 128'h0);
        checkOutput("reject.wr_en", 128'(coeff_wr_en), 128'h0);
        step();

        // Preset 0, sample_valid high for 10 cycles: write in cycle 11
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd0;
        step();
        cfg_preset_load = 1'b0;
        cfg_commit      = 1'b1;
        sample_valid    = 1'b1;
        step();
        cfg_commit = 1'b0;
        waitWrite(10, k);
        checkOutput("gap.cycle", 128'(k), 128'd11);
        step();
        @(negedge clk);
        checkOutput("gap.forced", 128'(forced), 128'h0);
        checkOutput("gap.done", 128'(done), 128'h1);
        step();

        // Preset 1, sample_valid stuck: forced write in cycle 64
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd1;
        step();
        cfg_preset_load = 1'b0;
        cfg_commit      = 1'b1;
        sample_valid    = 1'b1;
        step();
        cfg_commit = 1'b0;
        waitWrite(1000, k);
        checkOutput("timeout.cycle", 128'(k), 128'd64);
        step();
        @(negedge clk);
        checkOutput("timeout.forced", 128'(forced), 128'h1);
        checkOutput("timeout.done", 128'(done), 128'h1);
        sample_valid = 1'b0;
        step();

        // Readback corruption of A2
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd2;
        step();
        cfg_preset_load = 1'b0;
        cfg_commit      = 1'b1;
        corrupt         = 1'b1;
        step();
        cfg_commit = 1'b0;
        step();
        @(negedge clk);
        checkOutput("corrupt.done", 128'(done), 128'h0);
        step();
        @(negedge clk);
        checkOutput("corrupt.verify_err", 128'(verify_err), 128'h1);
        corrupt = 1'b0;

        // Illegal address and illegal preset select
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 3'd7;
        step();
        cfg_wr_valid = 1'b0;
        @(negedge clk);
        checkOutput("illegal.addr", 128'(cfg_err), 128'h1);
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd3;
        step();
        cfg_preset_load = 1'b0;
        @(negedge clk);
        checkOutput("illegal.sel", 128'(cfg_err), 128'h1);

        // Reset in the middle of a wait aborts at once
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd0;
        step();
        cfg_preset_load = 1'b0;
        cfg_commit      = 1'b1;
        sample_valid    = 1'b1;
        step();
        cfg_commit = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort.busy", 128'(busy), 128'h0);
        checkOutput("abort.b1", 128'(coeff_in[1]), 128'h5907C);
        step();
        rst_n = 1'b1;
        sample_valid = 1'b0;
        step();

        // Randomized traffic with increasing sample density
        applyStimulus(800, 50);
        applyStimulus(800, 90);
        applyStimulus(800, 99);

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
